eq_search_ctrl: RTL

//  - Sequential key-lookup controller: owns a DEPTH-entry table of N-bit words and time-shares ONE

---
 rtl/eq_search_pkg.sv | 8 +
 rtl/comparator_eq.sv | 10 +
 rtl/eq_search_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/eq_search_pkg.sv
// Shared types for the sequential key-lookup controller.
package eq_search_pkg;
  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } eq_search_state_t;
endpackage

// File: rtl/comparator_eq.sv
// Full-width bitwise equality comparator, shared by the table scan.
module comparator_eq #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out
);
  assign out = (a == b);
endmodule

// File: rtl/eq_search_ctrl.sv
// Sequential table search, one entry per clock through one comparator.
// Define EQ_SEARCH_COUNT_EN to scan the whole table and report the match count.
module eq_search_ctrl
  import eq_search_pkg::*;
#(
  parameter  int N     = 32,
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [N-1:0]     wr_data,
  input  logic             wr_vld,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N-1:0]     req_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic [IDX_W-1:0] rsp_idx,
`ifdef EQ_SEARCH_COUNT_EN
  output logic [IDX_W:0]   rsp_count,
`endif
  output logic             busy
);

  eq_search_state_t state_q, state_d;

  logic [N-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     key_q, key_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
`ifdef EQ_SEARCH_COUNT_EN
  logic [IDX_W:0]   cnt_q, cnt_d;
`endif

  logic eq;
  logic match;
  logic last;

  comparator_eq #(.N(N)) u_cmp (
    .a  (mem_q[idx_q]),
    .b  (key_q),
    .out(eq)
  );

  assign match = eq && vld_q[idx_q];
  assign last  = (idx_q == IDX_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vld_q   <= '0;
      idx_q   <= '0;
      key_q   <= '0;
      hit_q   <= 1'b0;
      ridx_q  <= '0;
`ifdef EQ_SEARCH_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      hit_q   <= hit_d;
      ridx_q  <= ridx_d;
`ifdef EQ_SEARCH_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Entry data is never reset; only the valid bits are.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_valid) state_d = S_SCAN;
`ifdef EQ_SEARCH_COUNT_EN
      S_SCAN: if (last) state_d = S_DONE;
`else
      S_SCAN: if (match || last) state_d = S_DONE;
`endif
      S_DONE: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vld_d  = vld_q;
    idx_d  = idx_q;
    key_d  = key_q;
    hit_d  = hit_q;
    ridx_d = ridx_q;
`ifdef EQ_SEARCH_COUNT_EN
    cnt_d  = cnt_q;
`endif
    if (wr_en) begin
      vld_d[wr_addr] = wr_vld;
    end
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          key_d  = req_key;
          idx_d  = '0;
          hit_d  = 1'b0;
          ridx_d = '0;
`ifdef EQ_SEARCH_COUNT_EN
          cnt_d  = '0;
`endif
        end
      end
      S_SCAN: begin
`ifdef EQ_SEARCH_COUNT_EN
        if (match) begin
          cnt_d = cnt_q + (IDX_W + 1)'(1);
          if (!hit_q) begin
            hit_d  = 1'b1;
            ridx_d = idx_q;
          end
        end
        if (!last) idx_d = idx_q + IDX_W'(1);
`else
        if (match) begin
          hit_d  = 1'b1;
          ridx_d = idx_q;
        end else if (!last) begin
          idx_d = idx_q + IDX_W'(1);
        end
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    rsp_hit   = hit_q;
    rsp_idx   = ridx_q;
`ifdef EQ_SEARCH_COUNT_EN
    rsp_count = cnt_q;
`endif
  end

endmodule
